// File: rtl/dsp_pkg.sv
// Shared types and constants for the dsp_mac_pipe MAC slice.
package dsp_pkg;

  // Field order matches the opmode bus: [3] post_sub .. [0] pre_sub.
  typedef struct packed {
    logic post_sub;
    logic z_sel_p;
    logic pre_bypass;
    logic pre_sub;
  } opmode_t;

  localparam int DSP_LAT = 4;

  localparam logic [3:0] OPM_ADD = 4'b0000;
  localparam logic [3:0] OPM_ACC = 4'b0100;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dsp_preadder.sv
// S2 stage of dsp_mac_pipe: full-precision pre-adder (D+B, D-B or B)
// with its result register. One extra bit over the wider operand means
// the add/sub never loses information.
module dsp_preadder
  import dsp_pkg::*;
#(
  parameter int BW     = 18,
  parameter int DW     = 18,
  parameter int SIGNED = 0,
  localparam int PREW  = max_int(BW, DW) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ce,
  input  logic [BW-1:0]   b,
  input  logic [DW-1:0]   d,
  input  logic            pre_sub,
  input  logic            pre_bypass,
  output logic [PREW-1:0] pre
);

  localparam logic SGN = (SIGNED != 0);

  logic [PREW-1:0] b_ext;
  logic [PREW-1:0] d_ext;
  logic [PREW-1:0] pre_d;
  logic [PREW-1:0] pre_q;

  // Extend both operands to the pre-adder width, then select the operation.
  always_comb begin
    b_ext = {{(PREW-BW){SGN & b[BW-1]}}, b};
    d_ext = {{(PREW-DW){SGN & d[DW-1]}}, d};
    pre_d = pre_q;
    if (ce) begin
      if (pre_bypass)   pre_d = b_ext;
      else if (pre_sub) pre_d = d_ext - b_ext;
      else              pre_d = d_ext + b_ext;
    end
  end

  // S2 result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre_q <= '0;
    else        pre_q <= pre_d;
  end

  assign pre = pre_q;

endmodule

// File: rtl/dsp_mac_pipe.sv
// dsp_mac_pipe: P = ((D op B) * A) post-op Z, 4-stage pipeline with valid
// tracking and clock-enable stall. Z is C or the block's own P (accumulate).
// Optional saturation of the S4 result is built when DSP_SAT_EN is defined;
// otherwise S4 wraps mod 2^PW and ovf is tied low.
module dsp_mac_pipe
  import dsp_pkg::*;
#(
  parameter int AW     = 18,
  parameter int BW     = 18,
  parameter int DW     = 18,
  parameter int CW     = 48,
  parameter int PW     = 48,
  parameter int SIGNED = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  input  logic          in_valid,
  input  logic [AW-1:0] A,
  input  logic [BW-1:0] B,
  input  logic [CW-1:0] C,
  input  logic [DW-1:0] D,
  input  logic [3:0]    opmode,
  output logic          out_valid,
  output logic [PW-1:0] P,
  output logic          ovf
);

  localparam int   PREW = max_int(BW, DW) + 1;
  localparam int   MW   = PREW + AW;
  localparam logic SGN  = (SIGNED != 0);

  // S1 signals
  logic          v1_d, v1_q;
  logic [AW-1:0] a1_d, a1_q;
  logic [BW-1:0] b1_d, b1_q;
  logic [CW-1:0] c1_d, c1_q;
  logic [DW-1:0] d1_d, d1_q;
  opmode_t       opm1_d, opm1_q;
  // S2 signals
  logic [PREW-1:0] pre2;
  logic            v2_d, v2_q, post_sub2_d, post_sub2_q, z_sel2_d, z_sel2_q;
  logic [AW-1:0]   a2_d, a2_q;
  logic [CW-1:0]   c2_d, c2_q;
  // S3 signals
  logic [MW-1:0] pre_x, a_x, m3_d, m3_q;
  logic          v3_d, v3_q, post_sub3_d, post_sub3_q, z_sel3_d, z_sel3_q;
  logic [CW-1:0] c3_d, c3_q;
  // S4 signals
  logic [PW-1:0] m_ext, c_ext, z, p_calc, p_d, p_q;
  logic          v4_d, v4_q;

  // S1: capture inputs when enabled.
  always_comb begin
    v1_d   = ce ? in_valid          : v1_q;
    a1_d   = ce ? A                 : a1_q;
    b1_d   = ce ? B                 : b1_q;
    c1_d   = ce ? C                 : c1_q;
    d1_d   = ce ? D                 : d1_q;
    opm1_d = ce ? opmode_t'(opmode) : opm1_q;
  end

  // S1 registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0; a1_q <= '0; b1_q <= '0; c1_q <= '0; d1_q <= '0; opm1_q <= '0;
    end else begin
      v1_q <= v1_d; a1_q <= a1_d; b1_q <= b1_d; c1_q <= c1_d; d1_q <= d1_d; opm1_q <= opm1_d;
    end
  end

  // S2: pre-adder lives in its own module; side-band fields travel alongside.
  dsp_preadder #(.BW(BW), .DW(DW), .SIGNED(SIGNED)) u_preadder (
    .clk        (clk),
    .rst_n      (rst_n),
    .ce         (ce),
    .b          (b1_q),
    .d          (d1_q),
    .pre_sub    (opm1_q.pre_sub),
    .pre_bypass (opm1_q.pre_bypass),
    .pre        (pre2)
  );

  // S2 side-band next state.
  always_comb begin
    v2_d        = ce ? v1_q            : v2_q;
    a2_d        = ce ? a1_q            : a2_q;
    c2_d        = ce ? c1_q            : c2_q;
    post_sub2_d = ce ? opm1_q.post_sub : post_sub2_q;
    z_sel2_d    = ce ? opm1_q.z_sel_p  : z_sel2_q;
  end

  // S2 side-band registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q <= 1'b0; a2_q <= '0; c2_q <= '0; post_sub2_q <= 1'b0; z_sel2_q <= 1'b0;
    end else begin
      v2_q <= v2_d; a2_q <= a2_d; c2_q <= c2_d; post_sub2_q <= post_sub2_d; z_sel2_q <= z_sel2_d;
    end
  end

  // S3: full-width product. Operands are pre-extended to MW bits so a plain
  // MW-bit multiply gives the exact two's-complement or unsigned product.
  always_comb begin
    pre_x       = {{AW{SGN & pre2[PREW-1]}}, pre2};
    a_x         = {{PREW{SGN & a2_q[AW-1]}}, a2_q};
    m3_d        = ce ? pre_x * a_x : m3_q;
    v3_d        = ce ? v2_q        : v3_q;
    c3_d        = ce ? c2_q        : c3_q;
    post_sub3_d = ce ? post_sub2_q : post_sub3_q;
    z_sel3_d    = ce ? z_sel2_q    : z_sel3_q;
  end

  // S3 registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m3_q <= '0; v3_q <= 1'b0; c3_q <= '0; post_sub3_q <= 1'b0; z_sel3_q <= 1'b0;
    end else begin
      m3_q <= m3_d; v3_q <= v3_d; c3_q <= c3_d; post_sub3_q <= post_sub3_d; z_sel3_q <= z_sel3_d;
    end
  end

  // Fit M and C to the P width: extend when narrower, truncate otherwise.
  if (PW > MW) begin : g_m_ext
    assign m_ext = {{(PW-MW){SGN & m3_q[MW-1]}}, m3_q};
  end else begin : g_m_trunc
    assign m_ext = m3_q[PW-1:0];
  end

  if (PW > CW) begin : g_c_ext
    assign c_ext = {{(PW-CW){SGN & c3_q[CW-1]}}, c3_q};
  end else begin : g_c_trunc
    assign c_ext = c3_q[PW-1:0];
  end

  // Z selection reads the live P register, so back-to-back accumulates chain.
  always_comb begin
    z = z_sel3_q ? p_q : c_ext;
  end

`ifdef DSP_SAT_EN
  logic [PW:0] z_x, m_x, sum_x;
  logic        ovf_now, ovf_d, ovf_q;

  // S4 post-add with one guard bit; clamp to the representable range on overflow.
  always_comb begin
    z_x     = {SGN & z[PW-1], z};
    m_x     = {SGN & m_ext[PW-1], m_ext};
    sum_x   = post_sub3_q ? (z_x - m_x) : (z_x + m_x);
    p_calc  = sum_x[PW-1:0];
    ovf_now = 1'b0;
    if (SGN) begin
      if (sum_x[PW] != sum_x[PW-1]) begin
        ovf_now = 1'b1;
        p_calc  = sum_x[PW] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
      end
    end else if (sum_x[PW]) begin
      ovf_now = 1'b1;
      p_calc  = post_sub3_q ? '0 : '1;
    end
    ovf_d = ovf_q | (ce & v3_q & ovf_now);
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  // S4 post-add, wrapping mod 2^PW.
  always_comb begin
    p_calc = post_sub3_q ? (z - m_ext) : (z + m_ext);
  end

  assign ovf = 1'b0;
`endif

  // S4 next state: P changes only on a valid enabled edge.
  always_comb begin
    p_d  = (ce && v3_q) ? p_calc : p_q;
    v4_d = ce ? v3_q : v4_q;
  end

  // S4 registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= '0; v4_q <= 1'b0;
    end else begin
      p_q <= p_d; v4_q <= v4_d;
    end
  end

  assign P         = p_q;
  assign out_valid = v4_q;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Self-checking bench for dsp_mac_pipe (unsigned, default widths).
// A transaction-level model predicts each result from the arithmetic
// rules and the order/timing of accepted samples.
module tb_dsp_mac_pipe;

  localparam longint unsigned MASK48 = 64'h0000_FFFF_FFFF_FFFF;
  localparam longint unsigned MASK19 = 64'h7_FFFF;
  localparam longint unsigned NONE   = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce;
  logic        in_valid;
  logic [17:0] a, b, d;
  logic [47:0] c;
  logic [3:0]  opmode;
  logic        out_valid;
  logic [47:0] p;
  logic        ovf;

  dsp_mac_pipe #(.AW(18), .BW(18), .DW(18), .CW(48), .PW(48), .SIGNED(0)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid),
    .A(a), .B(b), .C(c), .D(d), .opmode(opmode),
    .out_valid(out_valid), .P(p), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint unsigned a, b, c, d;
    logic [3:0]      opm;
    int              t;
  } smp_t;

  smp_t            pend[$];
  longint unsigned obs_p[$];
  int              obs_cyc[$];
  int              n_checks = 0;
  int              n_fail   = 0;
  int              edge_cnt = 0;
  int              cyc      = 0;
  logic            exp_v    = 1'b0;
  longint unsigned p_model  = 0;
  logic            ovf_model = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Result of one sample from the arithmetic definition.
  function automatic void model_apply(input smp_t s);
    longint unsigned pre, m, z;
    longint          r;
    if (s.opm[1])      pre = s.b;
    else if (s.opm[0]) pre = (s.d - s.b) & MASK19;
    else               pre = s.d + s.b;
    m = pre * s.a;
    z = s.opm[2] ? p_model : s.c;
    r = s.opm[3] ? (longint'(z) - longint'(m)) : longint'(z + m);
`ifdef DSP_SAT_EN
    if (r > longint'(MASK48)) begin p_model = MASK48; ovf_model = 1'b1; end
    else if (r < 0)           begin p_model = 0;      ovf_model = 1'b1; end
    else                      p_model = longint'(r);
`else
    p_model = longint'(r) & MASK48;
`endif
  endfunction

  function automatic longint unsigned get_p(input int i);
    return (i < obs_p.size()) ? obs_p[i] : NONE;
  endfunction

  function automatic int get_cyc(input int i);
    return (i < obs_cyc.size()) ? obs_cyc[i] : -1000;
  endfunction

  // One clock: advance the model by what was presented, then compare.
  task automatic step();
    smp_t s;
    logic took_ce, took_v;
    took_ce = ce; took_v = in_valid;
    s.a = a; s.b = b; s.c = c; s.d = d; s.opm = opmode; s.t = 0;
    @(posedge clk); #1;
    cyc++;
    if (!rst_n) begin
      pend.delete(); exp_v = 1'b0; p_model = 0; ovf_model = 1'b0;
    end else if (took_ce) begin
      edge_cnt++;
      s.t = edge_cnt;
      if (took_v) pend.push_back(s);
      exp_v = 1'b0;
      if (pend.size() > 0 && pend[0].t + 3 == edge_cnt) begin
        model_apply(pend.pop_front());
        exp_v = 1'b1;
      end
      if (out_valid) begin obs_p.push_back(p); obs_cyc.push_back(cyc); end
    end
    check("out_valid", out_valid, exp_v);
    check("P", p, p_model);
    check("ovf", ovf, ovf_model);
    $display("cyc %0d ce=%0b vin=%0b vout=%0b P=%0h ovf=%0b", cyc, took_ce, took_v, out_valid, p, ovf);
  endtask

  task automatic send(input logic [17:0] aa, input logic [17:0] bb, input logic [47:0] cc,
                      input logic [17:0] dd, input logic [3:0] om);
    a = aa; b = bb; c = cc; d = dd; opmode = om; in_valid = 1'b1; ce = 1'b1;
    step();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; ce = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  int t0, sent, guard;

  initial begin
    rst_n = 1'b0; ce = 1'b1; in_valid = 1'b0;
    a = '0; b = '0; c = '0; d = '0; opmode = '0;
    step(); step();
    check("reset_P", p, 0);
    check("reset_valid", out_valid, 0);
    rst_n = 1'b1;
    idle(2);

    // Legacy parity: (5+4)*3+10 = 37, four edges from acceptance.
    obs_p.delete(); obs_cyc.delete();
    t0 = cyc + 1;
    send(18'd3, 18'd4, 48'd10, 18'd5, 4'b0000);
    idle(6);
    check("t1_count", obs_p.size(), 1);
    check("t1_P", get_p(0), 37);
    check("t1_latency", get_cyc(0) - t0, 3);

    // Pre-sub (9-4)*5+10 = 35; pre-bypass 4*5+1 = 21.
    obs_p.delete(); obs_cyc.delete();
    send(18'd5, 18'd4, 48'd10, 18'd9, 4'b0001);
    send(18'd5, 18'd4, 48'd1,  18'd0, 4'b0010);
    idle(6);
    check("t2_sub", get_p(0), 35);
    check("t2_bypass", get_p(1), 21);

    // Accumulate chain: 4, 8, 12 on consecutive cycles.
    obs_p.delete(); obs_cyc.delete();
    send(18'd2, 18'd1, 48'd0,   18'd1, 4'b0000);
    send(18'd2, 18'd1, 48'd999, 18'd1, 4'b0100);
    send(18'd2, 18'd1, 48'd777, 18'd1, 4'b0100);
    idle(6);
    check("t3_acc0", get_p(0), 4);
    check("t3_acc1", get_p(1), 8);
    check("t3_acc2", get_p(2), 12);
    check("t3_gap01", get_cyc(1) - get_cyc(0), 1);
    check("t3_gap12", get_cyc(2) - get_cyc(1), 1);

    // Stall: 3 cycles of ce=0 (junk on inputs) delay the result by exactly 3.
    obs_p.delete(); obs_cyc.delete();
    t0 = cyc + 1;
    send(18'd2, 18'd3, 48'd7, 18'd4, 4'b0000);
    ce = 1'b0; in_valid = 1'b1; a = 18'd99; c = 48'd12345;
    for (int i = 0; i < 3; i++) step();
    idle(6);
    check("t4_stall_count", obs_p.size(), 1);
    check("t4_stall_P", get_p(0), 21);
    check("t4_stall_latency", get_cyc(0) - t0, 6);

    // Bubble: a 2-cycle input gap gives a 2-cycle output gap.
    obs_p.delete(); obs_cyc.delete();
    send(18'd1, 18'd1, 48'd5, 18'd1, 4'b0000);
    idle(2);
    send(18'd3, 18'd1, 48'd5, 18'd1, 4'b0000);
    idle(6);
    check("t4_bubble_P0", get_p(0), 7);
    check("t4_bubble_P1", get_p(1), 11);
    check("t4_bubble_gap", get_cyc(1) - get_cyc(0), 3);

    // Reset with three samples in flight: outputs clear at once, nothing emerges.
    obs_p.delete(); obs_cyc.delete();
    send(18'd4, 18'd4, 48'd1, 18'd4, 4'b0000);
    send(18'd5, 18'd4, 48'd1, 18'd4, 4'b0000);
    send(18'd6, 18'd4, 48'd1, 18'd4, 4'b0000);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t5_async_P", p, 0);
    check("t5_async_valid", out_valid, 0);
    check("t5_async_ovf", ovf, 0);
    step();
    rst_n = 1'b1;
    idle(6);
    check("t5_flushed", obs_p.size(), 0);

    // Overflow: (2^48-1) + 1.
    obs_p.delete(); obs_cyc.delete();
    send(18'd1, 18'd1, 48'hFFFF_FFFF_FFFF, 18'd0, 4'b0000);
    idle(6);
`ifdef DSP_SAT_EN
    check("t6_P", get_p(0), 64'h0000_FFFF_FFFF_FFFF);
    check("t6_ovf", ovf, 1);
`else
    check("t6_P", get_p(0), 0);
    check("t6_ovf", ovf, 0);
`endif

    // Random, opmode 0 then random opmodes, with random stalls and gaps.
    for (int phase = 0; phase < 2; phase++) begin
      sent = 0; guard = 0;
      while (sent < 100 && guard < 2000) begin
        guard++;
        a = 18'($urandom); b = 18'($urandom); d = 18'($urandom);
        c = {16'($urandom), 32'($urandom)};
        opmode = (phase == 0) ? 4'b0000 : 4'($urandom);
        ce = ($urandom_range(0, 3) != 0);
        in_valid = ($urandom_range(0, 2) != 0);
        if (ce && in_valid) sent++;
        step();
      end
      check("rand_budget", sent, 100);
    end
    idle(8);
    check("drain_empty", pend.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
